// File: rtl/input_buff_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// input_buff_ctrl
//   Sequencer for a K*K-bank replicated input feature-map buffer. A single
//   write port is broadcast to every bank, and each bank has its own read port.
//
//   The controller runs in two phases:
//     LOAD    : streams a full IMG_CH x IMG_H x IMG_W map into the buffer.
//     COMPUTE : issues one KxK window per cycle on all K*K read ports. Windows
//               are ordered by output row, then output column, then channel
//               (channel is the innermost loop).
//
//   Ports
//     clk, rstn        clock and asynchronous active-low reset
//     start            pulse that begins LOAD; honoured only in IDLE
//     in_valid/ready   pixel handshake; in_ready is high only in LOAD
//     in_data          input pixel, raster order ch, row, col
//     wea/addra/dia    registered broadcast write to the buffer
//                      (the bank-select bits of addra are always 0)
//     enb/addrb        per-port read enables, plus per-port addresses
//                      (port p uses bits [p*AW +: AW])
//     out_ready        downstream can take a window next cycle
//     win_valid/last   a window is on the buffer dob this cycle, and whether
//                      it is the final window of the map
//     busy/done        busy is high outside IDLE; done is a one-cycle end pulse
// ---------------------------------------------------------------------------
module input_buff_ctrl #(
    parameter int IMG_W      = 14,
    parameter int IMG_H      = 14,
    parameter int IMG_CH     = 6,
    parameter int K          = 5,
    parameter int SRAM_DEPTH = 1176,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = $clog2(SRAM_DEPTH),
    parameter int BW         = $clog2(K*K)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wea,
    output logic [AW+BW-1:0]      addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic [K*K-1:0]        enb,
    output logic [K*K*AW-1:0]     addrb,
    input  logic                  out_ready,
    output logic                  win_valid,
    output logic                  win_last,
    output logic                  busy,
    output logic                  done
);

    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;
    localparam int NP = K * K;

    localparam logic [AW-1:0] DEPTH_M1 = AW'(SRAM_DEPTH - 1);
    localparam logic [AW-1:0] OH_M1    = AW'(OH - 1);
    localparam logic [AW-1:0] OW_M1    = AW'(OW - 1);
    localparam logic [AW-1:0] CH_M1    = AW'(IMG_CH - 1);
    localparam logic [AW-1:0] PLANE    = AW'(IMG_H * IMG_W);
    localparam logic [AW-1:0] ROW      = AW'(IMG_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        FLUSH,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wcnt_q, wcnt_d;
    logic [AW-1:0]         oy_q, oy_d;
    logic [AW-1:0]         ox_q, ox_d;
    logic [AW-1:0]         ch_q, ch_d;
    logic [AW-1:0]         addra_q;
    logic [DATA_WIDTH-1:0] dia_q;
    logic                  wea_q;
    logic                  win_valid_q;
    logic                  win_last_q;
    logic                  accept;
    logic                  issue;
    logic                  last_win;
    logic [AW-1:0]         base;

    assign accept   = (state_q == LOAD) && in_valid;
    assign issue    = (state_q == COMPUTE) && out_ready;
    assign last_win = (oy_q == OH_M1) && (ox_q == OW_M1) && (ch_q == CH_M1);

    // Next-state logic, together with the write and window counter updates.
    // Window counters wrap back to zero after the final window, so a new run
    // starts from a clean position without needing a separate clear.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        ch_d    = ch_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (accept) begin
                    if (wcnt_q == DEPTH_M1) begin
                        wcnt_d  = '0;
                        state_d = COMPUTE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (issue) begin
                    if (ch_q == CH_M1) begin
                        ch_d = '0;
                        if (ox_q == OW_M1) begin
                            ox_d = '0;
                            if (oy_q == OH_M1) begin
                                oy_d    = '0;
                                state_d = FLUSH;
                            end else begin
                                oy_d = oy_q + 1'b1;
                            end
                        end else begin
                            ox_d = ox_q + 1'b1;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers. The write port is registered, so an
    // accepted pixel reaches the buffer one cycle after its handshake.
    // addra/dia keep their last values between writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            ch_q        <= '0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dia_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            ch_q        <= ch_d;
            wea_q       <= accept;
            win_valid_q <= issue;
            win_last_q  <= issue && last_win;
            if (accept) begin
                addra_q <= wcnt_q;
                dia_q   <= in_data;
            end
        end
    end

    // Top-left address of the current window within its channel plane.
    assign base = ch_q * PLANE + oy_q * ROW + ox_q;

    // Each read port adds a fixed (ky, kx) offset to the window base. The
    // addresses are forced to zero outside COMPUTE so that idle or reset
    // leaves the read bus quiet.
    for (genvar p = 0; p < NP; p++) begin : g_port
        localparam logic [AW-1:0] OFF = AW'((p / K) * IMG_W + (p % K));
        assign addrb[p*AW +: AW] = (state_q == COMPUTE) ? base + OFF : '0;
    end

    assign enb       = {NP{issue}};
    assign in_ready  = (state_q == LOAD);
    assign wea       = wea_q;
    assign addra     = {{BW{1'b0}}, addra_q};
    assign dia       = dia_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_input_buff_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for input_buff_ctrl. Expected writes are queued as pixels
// are handed over. Expected windows come from an independent loop model of
// the window order. A negedge monitor pops the expected entries and compares
// them as the DUT produces writes, read issues and valid windows.
module tb_input_buff_ctrl;

   localparam int IMG_W  = 14;
   localparam int IMG_H  = 14;
   localparam int IMG_CH = 6;
   localparam int K      = 5;
   localparam int DEPTH  = 1176;
   localparam int DW     = 8;
   localparam int AW     = 11;
   localparam int BW     = 5;
   localparam int NP     = K * K;
   localparam int OH     = IMG_H - K + 1;
   localparam int OW     = IMG_W - K + 1;
   localparam int NWIN   = OH * OW * IMG_CH;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              wea;
   logic [AW+BW-1:0]  addra;
   logic [DW-1:0]     dia;
   logic [NP-1:0]     enb;
   logic [NP*AW-1:0]  addrb;
   logic              out_ready;
   logic              win_valid;
   logic              win_last;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0]    wrAddrQ[$];
   logic [DW-1:0]    wrDataQ[$];
   logic [NP*AW-1:0] winQ[$];
   logic             lastQ[$];
   logic             pendLastQ[$];

   int   pixCount, weaCount, winCount, validCount;
   logic prevIssue, prevWinLast, prevDone, doneSeen, monOn;
   logic [AW-1:0] exA;
   logic [DW-1:0] exD;
   logic          exL;

   always #5 clk = ~clk;

   input_buff_ctrl dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .wea       (wea),
      .addra     (addra),
      .dia       (dia),
      .enb       (enb),
      .addrb     (addrb),
      .out_ready (out_ready),
      .win_valid (win_valid),
      .win_last  (win_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One stimulus cycle: inputs change just after the rising edge.
   task automatic applyStimulus(input logic s, input logic iv, input logic orr);
      @(posedge clk);
      #1;
      start     = s;
      in_valid  = iv;
      in_data   = pixCount[7:0];
      out_ready = orr;
   endtask

   task automatic resetBench();
      pixCount    = 0;
      weaCount    = 0;
      winCount    = 0;
      validCount  = 0;
      prevIssue   = 1'b0;
      prevWinLast = 1'b0;
      prevDone    = 1'b0;
      doneSeen    = 1'b0;
      wrAddrQ.delete();
      wrDataQ.delete();
      winQ.delete();
      lastQ.delete();
      pendLastQ.delete();
   endtask

   // Reference window order: row, then column, then channel innermost.
   task automatic fillWindows();
      logic [NP*AW-1:0] v;
      int base;
      for (int oy = 0; oy < OH; oy++)
         for (int ox = 0; ox < OW; ox++)
            for (int ch = 0; ch < IMG_CH; ch++) begin
               base = ch * IMG_H * IMG_W + oy * IMG_W + ox;
               v = '0;
               for (int ky = 0; ky < K; ky++)
                  for (int kx = 0; kx < K; kx++)
                     v[(ky*K+kx)*AW +: AW] = AW'(base + ky * IMG_W + kx);
               winQ.push_back(v);
               lastQ.push_back(oy == OH-1 && ox == OW-1 && ch == IMG_CH-1);
            end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_in_ready"},  512'(in_ready),  512'(0));
      checkOutput({tag, "_wea"},       512'(wea),       512'(0));
      checkOutput({tag, "_addra"},     512'(addra),     512'(0));
      checkOutput({tag, "_dia"},       512'(dia),       512'(0));
      checkOutput({tag, "_enb"},       512'(enb),       512'(0));
      checkOutput({tag, "_addrb"},     512'(addrb),     512'(0));
      checkOutput({tag, "_win_valid"}, 512'(win_valid), 512'(0));
      checkOutput({tag, "_win_last"},  512'(win_last),  512'(0));
      checkOutput({tag, "_busy"},      512'(busy),      512'(0));
      checkOutput({tag, "_done"},      512'(done),      512'(0));
   endtask

   // Monitor: retire writes and windows against the scoreboard queues.
   always @(negedge clk) begin
      if (monOn) begin
         if (wea) begin
            weaCount++;
            if (wrAddrQ.size() == 0) begin
               checkOutput("weaUnexpected", 512'(1), 512'(0));
            end else begin
               exA = wrAddrQ.pop_front();
               exD = wrDataQ.pop_front();
               checkOutput("addra", 512'(addra), 512'({{BW{1'b0}}, exA}));
               checkOutput("dia",   512'(dia),   512'(exD));
            end
         end
         if (in_valid && in_ready) begin
            wrAddrQ.push_back(AW'(pixCount));
            wrDataQ.push_back(pixCount[7:0]);
            pixCount++;
         end

         checkOutput("winValidAlign", 512'(win_valid), 512'(prevIssue));
         exL = 1'b0;
         if (win_valid) begin
            validCount++;
            if (pendLastQ.size() == 0) checkOutput("winValidUnexpected", 512'(1), 512'(0));
            else exL = pendLastQ.pop_front();
         end
         checkOutput("winLast", 512'(win_last), 512'(exL));

         if (enb != '0) begin
            winCount++;
            checkOutput("enb", 512'(enb), 512'({NP{1'b1}}));
            if (winQ.size() == 0) begin
               checkOutput("issueUnexpected", 512'(1), 512'(0));
            end else begin
               checkOutput("addrb", 512'(addrb), 512'(winQ.pop_front()));
               pendLastQ.push_back(lastQ.pop_front());
            end
         end

         checkOutput("done", 512'(done), 512'(prevWinLast));
         if (prevDone) checkOutput("busyAfterDone", 512'(busy), 512'(0));
         if (done) doneSeen = 1'b1;
         prevIssue   = (enb != '0);
         prevWinLast = win_valid && win_last;
         prevDone    = done;
      end
   end

   initial begin
      int  cyc;
      logic stallDone;
      rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      monOn = 1'b0;
      resetBench();
      #12;
      checkAllZero("reset");

      // Run 1: full load with bubbles, then compute with a stall.
      @(posedge clk); #1 rstn = 1'b1;
      resetBench();
      fillWindows();
      monOn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("inReadyAfterStart", 512'(in_ready), 512'(1));

      cyc = 0;
      while (pixCount < DEPTH && cyc < 10000) begin
         applyStimulus(cyc == 600, 1'($urandom_range(0, 1)), 1'b1);
         cyc++;
      end
      if (pixCount < DEPTH) checkOutput("loadTimeout", 512'(pixCount), 512'(DEPTH));
      @(negedge clk);
      checkOutput("inReadyAfterLoad", 512'(in_ready), 512'(0));

      cyc = 0;
      stallDone = 1'b0;
      while (!doneSeen && cyc < 3000) begin
         if (winCount >= 100 && !stallDone) begin
            for (int i = 0; i < 7; i++) begin
               applyStimulus(i == 3, 1'b0, 1'b0);
               @(negedge clk);
               checkOutput("stallEnb", 512'(enb), 512'(0));
            end
            stallDone = 1'b1;
         end else begin
            applyStimulus(1'b0, 1'b0, 1'b1);
         end
         cyc++;
      end
      checkOutput("doneSeen",   512'(doneSeen),       512'(1));
      checkOutput("weaCount",   512'(weaCount),       512'(DEPTH));
      checkOutput("winCount",   512'(winCount),       512'(NWIN));
      checkOutput("validCount", 512'(validCount),     512'(NWIN));
      checkOutput("winQEmpty",  512'(winQ.size()),    512'(0));
      checkOutput("wrQEmpty",   512'(wrAddrQ.size()), 512'(0));
      @(negedge clk);
      checkOutput("busyIdle", 512'(busy), 512'(0));

      // Run 2: reset in the middle of COMPUTE aborts the run.
      resetBench();
      fillWindows();
      applyStimulus(1'b1, 1'b1, 1'b1);
      cyc = 0;
      while (winCount < 20 && cyc < 3000) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         cyc++;
      end
      checkOutput("midComputeReached", 512'(winCount >= 20), 512'(1));
      @(posedge clk); #1;
      monOn = 1'b0;
      rstn  = 1'b0;
      #1;
      checkAllZero("midReset");
      @(posedge clk); #1 rstn = 1'b1;
      resetBench();
      monOn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("inReadyAfterReset", 512'(in_ready), 512'(1));
      checkOutput("doneAfterAbort",    512'(doneSeen), 512'(0));

      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
